// File: rtl/serial_parity_deframer.sv
// Serial-to-parallel deframer with even/odd parity and a one-word output buffer.
// Define SERIAL_PARITY_CHECK_EN to receive a trailing parity bit and flag parity_err.
module serial_parity_deframer #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_ODD = 0,
  localparam int CNT_W     = $clog2(DATA_W+2)
) (
  input  logic              clk,
  input  logic              asyn_rst,
  input  logic              clr,
  input  logic              valid_in,
  input  logic              data_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              parity,
`ifdef SERIAL_PARITY_CHECK_EN
  output logic              parity_err,
`endif
  output logic              valid_out,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              busy,
  output logic              overrun
);

`ifdef SERIAL_PARITY_CHECK_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic             ODD      = 1'(PARITY_ODD);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  out_state_e state_q, state_d;

  logic [DATA_W-1:0] sh_q, sh_d;
  logic              rpar_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              shift_en;
  logic              done;
  logic              load;
  logic              ovr_set;
  logic [DATA_W-1:0] word_new;
  logic              par_new;
`ifdef SERIAL_PARITY_CHECK_EN
  logic              perr_new;
`endif

  assign shift_en = valid_in & ~clr;
  assign done     = shift_en & (cnt_q == LAST_IDX);

  always_comb begin
    sh_d = sh_q;
    if (MSB_FIRST != 0)
      sh_d = {sh_q[DATA_W-2:0], data_in};
    else
      sh_d = {data_in, sh_q[DATA_W-1:1]};
  end

  // In check mode the last bit is the sender's parity, not data.
`ifdef SERIAL_PARITY_CHECK_EN
  assign word_new = sh_q;
  assign par_new  = rpar_q ^ ODD;
  assign perr_new = data_in ^ par_new;
`else
  assign word_new = sh_d;
  assign par_new  = rpar_q ^ data_in ^ ODD;
`endif

  always_ff @(posedge clk) begin
    if (!asyn_rst) begin
      sh_q   <= '0;
      rpar_q <= 1'b0;
      cnt_q  <= '0;
    end else if (clr) begin
      sh_q   <= '0;
      rpar_q <= 1'b0;
      cnt_q  <= '0;
    end else if (valid_in) begin
      if (done) begin
        sh_q   <= '0;
        rpar_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        sh_q   <= sh_d;
        rpar_q <= rpar_q ^ data_in;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovr_set = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (done) begin
          state_d = FULL;
          load    = 1'b1;
        end
      end
      FULL: begin
        if (done) begin
          if (out_ready) load = 1'b1;
          else ovr_set = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!asyn_rst) begin
      state_q    <= EMPTY;
      data_out   <= '0;
      parity     <= 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
      overrun    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_out   <= word_new;
        parity     <= par_new;
`ifdef SERIAL_PARITY_CHECK_EN
        parity_err <= perr_new;
`endif
      end
      if (clr) overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
    end
  end

  assign valid_out = (state_q == FULL);
  assign bit_cnt   = cnt_q;
  assign busy      = |cnt_q;

endmodule

// File: tb/tb_serial_parity_deframer.sv
// Directed bench for serial_parity_deframer: MSB-first even instance
// plus an LSB-first odd instance sharing the same serial stimulus.
module tb_serial_parity_deframer;

  localparam int W  = 8;
  localparam int CW = $clog2(W+2);

  logic         clk = 1'b0;
  logic         asyn_rst = 1'b0;
  logic         clr = 1'b0;
  logic         valid_in = 1'b0;
  logic         data_in = 1'b0;
  logic         out_ready = 1'b0;

  logic [W-1:0] dout_m, dout_l;
  logic         par_m, par_l;
  logic         vld_m, vld_l;
  logic [CW-1:0] cnt_m, cnt_l;
  logic         busy_m, busy_l;
  logic         ovr_m, ovr_l;
`ifdef SERIAL_PARITY_CHECK_EN
  logic         perr_m, perr_l;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_parity_deframer #(
    .DATA_W(W), .MSB_FIRST(1), .PARITY_ODD(0)
  ) u_msb (
    .clk(clk), .asyn_rst(asyn_rst), .clr(clr),
    .valid_in(valid_in), .data_in(data_in),
    .out_ready(out_ready), .data_out(dout_m),
    .parity(par_m),
`ifdef SERIAL_PARITY_CHECK_EN
    .parity_err(perr_m),
`endif
    .valid_out(vld_m), .bit_cnt(cnt_m),
    .busy(busy_m), .overrun(ovr_m)
  );

  serial_parity_deframer #(
    .DATA_W(W), .MSB_FIRST(0), .PARITY_ODD(1)
  ) u_lsb (
    .clk(clk), .asyn_rst(asyn_rst), .clr(clr),
    .valid_in(valid_in), .data_in(data_in),
    .out_ready(out_ready), .data_out(dout_l),
    .parity(par_l),
`ifdef SERIAL_PARITY_CHECK_EN
    .parity_err(perr_l),
`endif
    .valid_out(vld_l), .bit_cnt(cnt_l),
    .busy(busy_l), .overrun(ovr_l)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    valid_in = 1'b1;
    data_in  = b;
    tick();
    valid_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W-1; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    logic [W-1:0] pat;

    tick();
    tick();
    chk("rst_data", 64'(dout_m), 64'h0);
    chk("rst_par", 64'(par_m), 64'h0);
    chk("rst_vld", 64'(vld_m), 64'h0);
    chk("rst_cnt", 64'(cnt_m), 64'h0);
    chk("rst_busy", 64'(busy_m), 64'h0);
    chk("rst_ovr", 64'(ovr_m), 64'h0);
`ifdef SERIAL_PARITY_CHECK_EN
    chk("rst_perr", 64'(perr_m), 64'h0);
`endif
    asyn_rst = 1'b1;
    tick();

`ifdef SERIAL_PARITY_CHECK_EN
    out_ready = 1'b1;
    send_word(8'hB2);
    chk("pc_cnt8", 64'(cnt_m), 64'd8);
    chk("pc_vld0", 64'(vld_m), 64'h0);
    send_bit(1'b1);
    chk("pc1_data", 64'(dout_m), 64'hB2);
    chk("pc1_par", 64'(par_m), 64'h0);
    chk("pc1_perr", 64'(perr_m), 64'h1);
    chk("pc1_vld", 64'(vld_m), 64'h1);
    chk("pc1_cnt", 64'(cnt_m), 64'h0);
    send_word(8'hB2);
    send_bit(1'b0);
    chk("pc0_data", 64'(dout_m), 64'hB2);
    chk("pc0_perr", 64'(perr_m), 64'h0);
`else
    // basic MSB-first frame 1,0,1,1,0,0,1,0
    out_ready = 1'b1;
    pat = 8'hB2;
    for (int i = 7; i >= 5; i--) send_bit(pat[i]);
    chk("mid_cnt", 64'(cnt_m), 64'd3);
    chk("mid_busy", 64'(busy_m), 64'h1);
    chk("mid_vld", 64'(vld_m), 64'h0);
    for (int i = 4; i >= 0; i--) send_bit(pat[i]);
    chk("b2_data", 64'(dout_m), 64'hB2);
    chk("b2_par", 64'(par_m), 64'h0);
    chk("b2_vld", 64'(vld_m), 64'h1);
    chk("b2_cnt", 64'(cnt_m), 64'h0);
    chk("b2_busy", 64'(busy_m), 64'h0);
    chk("lsb_4d", 64'(dout_l), 64'h4D);
    chk("lsb_4d_par", 64'(par_l), 64'h1);
    tick();
    chk("b2_vld_drop", 64'(vld_m), 64'h0);
    chk("b2_hold", 64'(dout_m), 64'hB2);

    // LSB-first odd parity with 2-cycle gaps
    pat = 8'hC0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(pat[i]);
      if (i == 6) begin
        tick();
        tick();
        chk("gap_cnt", 64'(cnt_l), 64'd2);
      end else if (i != 0) begin
        tick();
        tick();
      end
    end
    chk("gap_data", 64'(dout_l), 64'h03);
    chk("gap_par", 64'(par_l), 64'h1);
    chk("gap_vld", 64'(vld_l), 64'h1);
    chk("gap_msb", 64'(dout_m), 64'hC0);
    tick();

    // back-pressure and overrun
    out_ready = 1'b0;
    send_word(8'hFF);
    chk("ff_data", 64'(dout_m), 64'hFF);
    chk("ff_vld", 64'(vld_m), 64'h1);
    send_word(8'h01);
    chk("ovr_data", 64'(dout_m), 64'hFF);
    chk("ovr_par", 64'(par_m), 64'h0);
    chk("ovr_flag", 64'(ovr_m), 64'h1);
    chk("ovr_vld", 64'(vld_m), 64'h1);
    out_ready = 1'b1;
    tick();
    chk("acc_vld", 64'(vld_m), 64'h0);
    chk("acc_data", 64'(dout_m), 64'hFF);
    chk("ovr_sticky", 64'(ovr_m), 64'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_clr", 64'(ovr_m), 64'h0);

    // back-to-back accept, no bubble
    out_ready = 1'b0;
    send_word(8'h3C);
    chk("b2b_first", 64'(dout_m), 64'h3C);
    pat = 8'h5A;
    for (int i = 7; i >= 1; i--) send_bit(pat[i]);
    out_ready = 1'b1;
    send_bit(pat[0]);
    chk("b2b_vld", 64'(vld_m), 64'h1);
    chk("b2b_data", 64'(dout_m), 64'h5A);
    chk("b2b_ovr", 64'(ovr_m), 64'h0);
    tick();
    chk("b2b_drain", 64'(vld_m), 64'h0);

    // clr mid-frame beats valid_in
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("clr_pre", 64'(cnt_m), 64'd5);
    clr = 1'b1;
    valid_in = 1'b1;
    data_in = 1'b1;
    tick();
    clr = 1'b0;
    valid_in = 1'b0;
    chk("clr_cnt", 64'(cnt_m), 64'h0);
    send_word(8'hA5);
    chk("a5_data", 64'(dout_m), 64'hA5);
    chk("a5_par", 64'(par_m), 64'h0);
    tick();

    // reset mid-frame
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    asyn_rst = 1'b0;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("mrst_data", 64'(dout_m), 64'h0);
    chk("mrst_vld", 64'(vld_m), 64'h0);
    chk("mrst_cnt", 64'(cnt_m), 64'h0);
    chk("mrst_par", 64'(par_m), 64'h0);
    asyn_rst = 1'b1;
    send_word(8'h81);
    chk("post_data", 64'(dout_m), 64'h81);
    chk("post_par", 64'(par_m), 64'h0);
    chk("post_vld", 64'(vld_m), 64'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
